// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog - single-clock FIFO with generic width/depth (any depth >= 2),
// run-time programmable almost-full/almost-empty thresholds, selectable
// first-word-fall-through read mode, overflow/underflow pulses and a
// read-data-valid strobe.
//
// Parameters
//   WIDTH  data width in bits
//   DEPTH  number of storage words (>= 2, need not be a power of two)
//   CNT_W  width of count/threshold ports, 2**CNT_W > DEPTH
//   FWFT   0 = registered read (Q one cycle after RE), 1 = first-word-fall-through
//
// Ports
//   CLK, RESET         rising-edge clock, asynchronous active-high reset
//   WE, DATA           write request and write data
//   RE                 read request (FWFT=0) or pop of the shown word (FWFT=1)
//   AFVAL, AEVAL       almost-full / almost-empty thresholds (unsigned)
//   Q, DVLD            read data and its valid strobe
//   FULL, EMPTY        registered occupancy flags
//   AFULL, AEMPTY      registered threshold flags
//   OVERFLOW/UNDERFLOW single-cycle pulse after a rejected write/read
//   WRCNT, RDCNT       occupancy (both equal the stored word count)
//
// Handshake: a write transfers on an edge where WE is high and FULL (the
// registered flag of that cycle) is low; a read/pop transfers on an edge where
// RE is high and EMPTY is low. A request against the wrong flag is dropped
// without side effects other than the error pulse on the following cycle.
module sync_fifo_prog #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 480,
  parameter int CNT_W = 10,
  parameter int FWFT  = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WE,
  input  logic [WIDTH-1:0] DATA,
  input  logic             RE,
  input  logic [CNT_W-1:0] AFVAL,
  input  logic [CNT_W-1:0] AEVAL,
  output logic [WIDTH-1:0] Q,
  output logic             DVLD,
  output logic             FULL,
  output logic             EMPTY,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  output logic [CNT_W-1:0] WRCNT,
  output logic [CNT_W-1:0] RDCNT
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             full_r, empty_r, afull_r, aempty_r;
  logic             first_cycle;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] head_nxt;
  logic [WIDTH-1:0] q_r;
  logic             dvld_r;

  always_comb begin
    wr_ok = WE && !full_r;
    rd_ok = RE && !empty_r;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    wr_ptr_nxt = wr_ptr;
    if (wr_ok) begin
      wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
    end
    rd_ptr_nxt = rd_ptr;
    if (rd_ok) begin
      rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
    end

    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase

    // Word that will be at the head after this edge. If that slot is being
    // written on this same edge the memory does not hold it yet, so the
    // incoming DATA is forwarded instead (write into empty, or pop+write at
    // a count of one).
    head_nxt = (wr_ok && (rd_ptr_nxt == wr_ptr)) ? DATA : mem[rd_ptr_nxt];
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wr_ptr] <= DATA;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      afull_r     <= 1'b0;
      aempty_r    <= 1'b1;
      OVERFLOW    <= 1'b0;
      UNDERFLOW   <= 1'b0;
      first_cycle <= 1'b1;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      full_r      <= (count_nxt == DEPTH_CNT);
      empty_r     <= (count_nxt == '0);
      afull_r     <= (count_nxt >= AFVAL);
      aempty_r    <= (count_nxt <= AEVAL);
      OVERFLOW    <= WE && full_r;
      UNDERFLOW   <= RE && empty_r;
      first_cycle <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_r    <= '0;
      dvld_r <= 1'b0;
    end else if (FWFT != 0) begin
      // Q tracks the head whenever the FIFO is non-empty; when it drains, Q
      // keeps the last word shown rather than exposing stale memory.
      dvld_r <= (count_nxt != '0);
      if (count_nxt != '0) begin
        q_r <= head_nxt;
      end
    end else begin
      dvld_r <= rd_ok;
      if (rd_ok) begin
        q_r <= mem[rd_ptr];
      end
    end
  end

  // While in reset, and in the cycle before the first edge after release,
  // count is known to be zero, so AFULL is simply (0 >= AFVAL), i.e. AFVAL==0.
  // Afterwards the registered comparison takes over.
  assign AFULL  = first_cycle ? (AFVAL == '0) : afull_r;
  assign FULL   = full_r;
  assign EMPTY  = empty_r;
  assign AEMPTY = aempty_r;
  assign Q      = q_r;
  assign DVLD   = dvld_r;
  assign WRCNT  = count;
  assign RDCNT  = count;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog - self-checking bench for sync_fifo_prog.
// Instance a: 32x480, FWFT=0 (directed reset, fill/wrap, threshold and
// simultaneous-access scenarios). Instances b (FWFT=0) and c (FWFT=1): 8x5,
// CNT_W=3, sharing one stimulus; used for the FWFT scenario and a random run
// against a queue-based model.
module tb_sync_fifo_prog;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance a: 32 x 480, FWFT=0 ----------------
  logic        a_we, a_re;
  logic [31:0] a_data, a_q;
  logic [9:0]  a_afval, a_aeval, a_wrcnt, a_rdcnt;
  logic        a_dvld, a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;

  sync_fifo_prog #(.WIDTH(32), .DEPTH(480), .CNT_W(10), .FWFT(0)) u_a (
    .CLK(clk), .RESET(rst), .WE(a_we), .DATA(a_data), .RE(a_re),
    .AFVAL(a_afval), .AEVAL(a_aeval), .Q(a_q), .DVLD(a_dvld),
    .FULL(a_full), .EMPTY(a_empty), .AFULL(a_afull), .AEMPTY(a_aempty),
    .OVERFLOW(a_ovf), .UNDERFLOW(a_udf), .WRCNT(a_wrcnt), .RDCNT(a_rdcnt)
  );

  // ---------------- instances b (FWFT=0) and c (FWFT=1): 8 x 5 ----------------
  logic       s_we, s_re;
  logic [7:0] s_data;
  logic [2:0] s_afval, s_aeval;
  logic [7:0] b_q, c_q;
  logic [2:0] b_wrcnt, b_rdcnt, c_wrcnt, c_rdcnt;
  logic       b_dvld, b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
  logic       c_dvld, c_full, c_empty, c_afull, c_aempty, c_ovf, c_udf;

  sync_fifo_prog #(.WIDTH(8), .DEPTH(5), .CNT_W(3), .FWFT(0)) u_b (
    .CLK(clk), .RESET(rst), .WE(s_we), .DATA(s_data), .RE(s_re),
    .AFVAL(s_afval), .AEVAL(s_aeval), .Q(b_q), .DVLD(b_dvld),
    .FULL(b_full), .EMPTY(b_empty), .AFULL(b_afull), .AEMPTY(b_aempty),
    .OVERFLOW(b_ovf), .UNDERFLOW(b_udf), .WRCNT(b_wrcnt), .RDCNT(b_rdcnt)
  );

  sync_fifo_prog #(.WIDTH(8), .DEPTH(5), .CNT_W(3), .FWFT(1)) u_c (
    .CLK(clk), .RESET(rst), .WE(s_we), .DATA(s_data), .RE(s_re),
    .AFVAL(s_afval), .AEVAL(s_aeval), .Q(c_q), .DVLD(c_dvld),
    .FULL(c_full), .EMPTY(c_empty), .AFULL(c_afull), .AEMPTY(c_aempty),
    .OVERFLOW(c_ovf), .UNDERFLOW(c_udf), .WRCNT(c_wrcnt), .RDCNT(c_rdcnt)
  );

  // ---------------- scoreboard queues ----------------
  logic [31:0] a_exp_q[$];
  logic [7:0]  b_exp_q[$];
  logic [7:0]  c_exp_q[$];

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic we, input logic re, input logic [31:0] d);
    a_we = we; a_re = re; a_data = d;
    tick();
  endtask

  task automatic s_drive(input logic we, input logic re, input logic [7:0] d);
    s_we = we; s_re = re; s_data = d;
    tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 100; i++) a_drive(1'b1, 1'b0, 32'(i + 1));
    for (int i = 0; i < 3; i++) a_drive(1'b0, 1'b1, 32'h0);
    a_drive(1'b0, 1'b0, 32'h0);
    n_checks++; if (a_q !== 32'd3) begin n_fail++; $display("FAIL pre_rst_q: got %0h want 3", a_q); end
    n_checks++; if (a_wrcnt !== 10'd97) begin n_fail++; $display("FAIL pre_rst_cnt: got %0d want 97", a_wrcnt); end
    // Asynchronous reset, checked with no clock edge in between.
    rst = 1'b1;
    a_afval = 10'd0;
    #1;
    n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", a_empty); end
    n_checks++; if (a_aempty !== 1'b1) begin n_fail++; $display("FAIL rst_aempty: got %b want 1", a_aempty); end
    n_checks++; if (a_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", a_full); end
    n_checks++; if (a_wrcnt !== 10'd0) begin n_fail++; $display("FAIL rst_wrcnt: got %0d want 0", a_wrcnt); end
    n_checks++; if (a_rdcnt !== 10'd0) begin n_fail++; $display("FAIL rst_rdcnt: got %0d want 0", a_rdcnt); end
    n_checks++; if (a_q !== 32'h0) begin n_fail++; $display("FAIL rst_q: got %0h want 0", a_q); end
    n_checks++; if (a_dvld !== 1'b0) begin n_fail++; $display("FAIL rst_dvld: got %b want 0", a_dvld); end
    n_checks++; if ({a_ovf, a_udf} !== 2'b00) begin n_fail++; $display("FAIL rst_err: got %b want 00", {a_ovf, a_udf}); end
    n_checks++; if (a_afull !== 1'b1) begin n_fail++; $display("FAIL rst_afull_afval0: got %b want 1", a_afull); end
    a_afval = 10'd400;
    #1;
    n_checks++; if (a_afull !== 1'b0) begin n_fail++; $display("FAIL rst_afull: got %b want 0", a_afull); end
    rst = 1'b0;
    a_drive(1'b1, 1'b0, 32'hA5A5_A5A5);
    n_checks++; if (a_wrcnt !== 10'd1) begin n_fail++; $display("FAIL post_rst_cnt: got %0d want 1", a_wrcnt); end
    a_drive(1'b0, 1'b1, 32'h0);
    n_checks++; if (a_q !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL post_rst_first_word: got %0h want a5a5a5a5", a_q); end
    n_checks++; if (a_dvld !== 1'b1) begin n_fail++; $display("FAIL post_rst_dvld: got %b want 1", a_dvld); end
    a_drive(1'b0, 1'b0, 32'h0);
    n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL post_rst_empty: got %b want 1", a_empty); end
  endtask

  task automatic test_fill_wrap();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 480; i++) begin
        a_drive(1'b1, 1'b0, 32'(rep * 1000 + i));
        n_checks++; if (a_full !== (i == 479)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, a_full, (i == 479)); end
      end
      a_drive(1'b1, 1'b0, 32'hBAD0_BAD0);
      n_checks++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %b want 1", a_ovf); end
      n_checks++; if (a_wrcnt !== 10'd480) begin n_fail++; $display("FAIL fill_cnt: got %0d want 480", a_wrcnt); end
      a_drive(1'b0, 1'b0, 32'h0);
      n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_pulse: got %b want 0", a_ovf); end
      for (int i = 0; i < 480; i++) begin
        a_drive(1'b0, 1'b1, 32'h0);
        n_checks++; if (a_dvld !== 1'b1) begin n_fail++; $display("FAIL drain_dvld[%0d]: got %b want 1", i, a_dvld); end
        n_checks++; if (a_q !== 32'(rep * 1000 + i)) begin n_fail++; $display("FAIL drain_q[%0d]: got %0d want %0d", i, a_q, rep * 1000 + i); end
      end
      a_drive(1'b0, 1'b0, 32'h0);
      n_checks++; if (a_dvld !== 1'b0) begin n_fail++; $display("FAIL drain_dvld_end: got %b want 0", a_dvld); end
      n_checks++; if (a_q !== 32'(rep * 1000 + 479)) begin n_fail++; $display("FAIL drain_q_hold: got %0d want %0d", a_q, rep * 1000 + 479); end
      n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", a_empty); end
    end
  endtask

  task automatic test_thresholds();
    a_afval = 10'd400; a_aeval = 10'd4;
    a_drive(1'b0, 1'b0, 32'h0);
    n_checks++; if (a_aempty !== 1'b1) begin n_fail++; $display("FAIL thr_aempty0: got %b want 1", a_aempty); end
    for (int c = 1; c <= 400; c++) begin
      a_drive(1'b1, 1'b0, 32'(c));
      if (c <= 5) begin
        n_checks++; if (a_aempty !== (c <= 4)) begin n_fail++; $display("FAIL thr_aempty[%0d]: got %b want %b", c, a_aempty, (c <= 4)); end
      end
      if (c >= 399) begin
        n_checks++; if (a_afull !== (c >= 400)) begin n_fail++; $display("FAIL thr_afull[%0d]: got %b want %b", c, a_afull, (c >= 400)); end
      end
    end
    for (int i = 0; i < 350; i++) a_drive(1'b0, 1'b1, 32'h0);
    n_checks++; if (a_wrcnt !== 10'd50) begin n_fail++; $display("FAIL thr_cnt50: got %0d want 50", a_wrcnt); end
    n_checks++; if (a_afull !== 1'b0) begin n_fail++; $display("FAIL thr_afull50: got %b want 0", a_afull); end
    a_afval = 10'd10;
    #1;
    n_checks++; if (a_afull !== 1'b0) begin n_fail++; $display("FAIL thr_afval_early: got %b want 0", a_afull); end
    a_drive(1'b0, 1'b0, 32'h0);
    n_checks++; if (a_afull !== 1'b1) begin n_fail++; $display("FAIL thr_afval_change: got %b want 1", a_afull); end
    a_aeval = 10'd0;
    for (int k = 49; k >= 0; k--) begin
      a_drive(1'b0, 1'b1, 32'h0);
      if (k == 10 || k == 9) begin
        n_checks++; if (a_afull !== (k >= 10)) begin n_fail++; $display("FAIL thr_afull10[%0d]: got %b want %b", k, a_afull, (k >= 10)); end
      end
      if (k <= 1) begin
        n_checks++; if (a_aempty !== (k == 0)) begin n_fail++; $display("FAIL thr_aeval0[%0d]: got %b want %b", k, a_aempty, (k == 0)); end
      end
    end
    a_afval = 10'd1000; a_aeval = 10'd4;
    a_drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp;
    a_exp_q.delete();
    // Empty: the write is taken, the read is rejected.
    a_drive(1'b1, 1'b1, 32'h1000);
    a_exp_q.push_back(32'h1000);
    n_checks++; if (a_wrcnt !== 10'd1) begin n_fail++; $display("FAIL sim_empty_cnt: got %0d want 1", a_wrcnt); end
    n_checks++; if (a_udf !== 1'b1) begin n_fail++; $display("FAIL sim_empty_udf: got %b want 1", a_udf); end
    n_checks++; if (a_dvld !== 1'b0) begin n_fail++; $display("FAIL sim_empty_dvld: got %b want 0", a_dvld); end
    for (int i = 1; i < 480; i++) begin
      a_drive(1'b1, 1'b0, 32'h1000 + 32'(i));
      a_exp_q.push_back(32'h1000 + 32'(i));
    end
    n_checks++; if (a_full !== 1'b1) begin n_fail++; $display("FAIL sim_full: got %b want 1", a_full); end
    n_checks++; if (a_afull !== 1'b0) begin n_fail++; $display("FAIL sim_afull_above_depth: got %b want 0", a_afull); end
    // Full: the read is taken, the write is rejected.
    a_drive(1'b1, 1'b1, 32'hDEAD_BEEF);
    exp = a_exp_q.pop_front();
    n_checks++; if (a_wrcnt !== 10'd479) begin n_fail++; $display("FAIL sim_full_cnt: got %0d want 479", a_wrcnt); end
    n_checks++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL sim_full_ovf: got %b want 1", a_ovf); end
    n_checks++; if (a_q !== exp) begin n_fail++; $display("FAIL sim_full_q: got %0h want %0h", a_q, exp); end
    for (int i = 0; i < 279; i++) begin
      a_drive(1'b0, 1'b1, 32'h0);
      exp = a_exp_q.pop_front();
      n_checks++; if (a_q !== exp) begin n_fail++; $display("FAIL sim_drain_q: got %0h want %0h", a_q, exp); end
    end
    n_checks++; if (a_wrcnt !== 10'd200) begin n_fail++; $display("FAIL sim_cnt200: got %0d want 200", a_wrcnt); end
    for (int i = 0; i < 50; i++) begin
      a_drive(1'b1, 1'b1, 32'h2000 + 32'(i));
      exp = a_exp_q.pop_front();
      a_exp_q.push_back(32'h2000 + 32'(i));
      n_checks++; if (a_q !== exp) begin n_fail++; $display("FAIL sim_rw_q[%0d]: got %0h want %0h", i, a_q, exp); end
      n_checks++; if (a_wrcnt !== 10'd200) begin n_fail++; $display("FAIL sim_rw_cnt[%0d]: got %0d want 200", i, a_wrcnt); end
    end
    for (int i = 0; i < 200; i++) begin
      a_drive(1'b0, 1'b1, 32'h0);
      exp = a_exp_q.pop_front();
      n_checks++; if (a_q !== exp) begin n_fail++; $display("FAIL sim_final_q[%0d]: got %0h want %0h", i, a_q, exp); end
    end
    a_drive(1'b0, 1'b0, 32'h0);
    n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL sim_final_empty: got %b want 1", a_empty); end
  endtask

  task automatic test_fwft();
    s_afval = 3'd4; s_aeval = 3'd1;
    pulse_reset();
    s_drive(1'b1, 1'b0, 8'h11);
    n_checks++; if (c_q !== 8'h11) begin n_fail++; $display("FAIL fwft_first_q: got %0h want 11", c_q); end
    n_checks++; if (c_dvld !== 1'b1) begin n_fail++; $display("FAIL fwft_first_dvld: got %b want 1", c_dvld); end
    s_drive(1'b1, 1'b0, 8'h22);
    n_checks++; if (c_q !== 8'h11) begin n_fail++; $display("FAIL fwft_head_stable: got %0h want 11", c_q); end
    s_drive(1'b0, 1'b1, 8'h00);
    n_checks++; if (c_q !== 8'h22) begin n_fail++; $display("FAIL fwft_pop_q: got %0h want 22", c_q); end
    s_drive(1'b0, 1'b1, 8'h00);
    n_checks++; if (c_empty !== 1'b1) begin n_fail++; $display("FAIL fwft_empty: got %b want 1", c_empty); end
    n_checks++; if (c_dvld !== 1'b0) begin n_fail++; $display("FAIL fwft_dvld_low: got %b want 0", c_dvld); end
    n_checks++; if (c_q !== 8'h22) begin n_fail++; $display("FAIL fwft_q_held: got %0h want 22", c_q); end
    s_drive(1'b1, 1'b1, 8'h33);
    n_checks++; if (c_udf !== 1'b1) begin n_fail++; $display("FAIL fwft_sim_udf: got %b want 1", c_udf); end
    n_checks++; if (c_q !== 8'h33) begin n_fail++; $display("FAIL fwft_sim_q: got %0h want 33", c_q); end
    n_checks++; if (c_wrcnt !== 3'd1) begin n_fail++; $display("FAIL fwft_sim_cnt: got %0d want 1", c_wrcnt); end
    s_drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] b_q_exp, c_q_exp;
    logic       we, re, e_ovf, e_udf, e_bdvld, e_cdvld, e_afull, e_aempty;
    logic [7:0] d;
    int         size;
    pulse_reset();
    b_exp_q.delete(); c_exp_q.delete();
    b_q_exp = 8'h00; c_q_exp = 8'h00;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (cyc % 50 == 0) begin
        s_afval = 3'($urandom_range(0, 7));
        s_aeval = 3'($urandom_range(0, 7));
      end
      // Alternate write-heavy and read-heavy phases to visit full and empty.
      we = ($urandom_range(0, 99) < (((cyc / 100) % 2 == 0) ? 70 : 30));
      re = ($urandom_range(0, 99) < (((cyc / 100) % 2 == 0) ? 30 : 70));
      d  = 8'($urandom_range(0, 255));
      // Model: decisions use the occupancy before the edge.
      size  = b_exp_q.size();
      e_ovf = we && (size == 5);
      e_udf = re && (size == 0);
      e_bdvld = re && (size > 0);
      if (re && size > 0) begin
        b_q_exp = b_exp_q.pop_front();
        void'(c_exp_q.pop_front());
      end
      if (we && size < 5) begin
        b_exp_q.push_back(d);
        c_exp_q.push_back(d);
      end
      size     = b_exp_q.size();
      e_afull  = (size >= int'(s_afval));
      e_aempty = (size <= int'(s_aeval));
      e_cdvld  = (size > 0);
      if (size > 0) c_q_exp = c_exp_q[0];
      s_drive(we, re, d);
      n_checks++; if (b_wrcnt !== 3'(size) || b_rdcnt !== 3'(size)) begin n_fail++; $display("FAIL rnd_b_cnt[%0d]: got %0d/%0d want %0d", cyc, b_wrcnt, b_rdcnt, size); end
      n_checks++; if (c_wrcnt !== 3'(size) || c_rdcnt !== 3'(size)) begin n_fail++; $display("FAIL rnd_c_cnt[%0d]: got %0d/%0d want %0d", cyc, c_wrcnt, c_rdcnt, size); end
      n_checks++; if ({b_full, b_empty} !== {size == 5, size == 0}) begin n_fail++; $display("FAIL rnd_b_fe[%0d]: got %b%b want %b%b", cyc, b_full, b_empty, size == 5, size == 0); end
      n_checks++; if ({c_full, c_empty} !== {size == 5, size == 0}) begin n_fail++; $display("FAIL rnd_c_fe[%0d]: got %b%b want %b%b", cyc, c_full, c_empty, size == 5, size == 0); end
      n_checks++; if ({b_afull, b_aempty} !== {e_afull, e_aempty}) begin n_fail++; $display("FAIL rnd_b_thr[%0d]: got %b%b want %b%b", cyc, b_afull, b_aempty, e_afull, e_aempty); end
      n_checks++; if ({c_afull, c_aempty} !== {e_afull, e_aempty}) begin n_fail++; $display("FAIL rnd_c_thr[%0d]: got %b%b want %b%b", cyc, c_afull, c_aempty, e_afull, e_aempty); end
      n_checks++; if ({b_ovf, b_udf} !== {e_ovf, e_udf}) begin n_fail++; $display("FAIL rnd_b_err[%0d]: got %b%b want %b%b", cyc, b_ovf, b_udf, e_ovf, e_udf); end
      n_checks++; if ({c_ovf, c_udf} !== {e_ovf, e_udf}) begin n_fail++; $display("FAIL rnd_c_err[%0d]: got %b%b want %b%b", cyc, c_ovf, c_udf, e_ovf, e_udf); end
      n_checks++; if (b_dvld !== e_bdvld || b_q !== b_q_exp) begin n_fail++; $display("FAIL rnd_b_data[%0d]: got %b/%0h want %b/%0h", cyc, b_dvld, b_q, e_bdvld, b_q_exp); end
      n_checks++; if (c_dvld !== e_cdvld || c_q !== c_q_exp) begin n_fail++; $display("FAIL rnd_c_data[%0d]: got %b/%0h want %b/%0h", cyc, c_dvld, c_q, e_cdvld, c_q_exp); end
    end
    s_drive(1'b0, 1'b0, 8'h00);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    a_we = 1'b0; a_re = 1'b0; a_data = '0; a_afval = 10'd400; a_aeval = 10'd4;
    s_we = 1'b0; s_re = 1'b0; s_data = '0; s_afval = 3'd4; s_aeval = 3'd1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_fill_wrap();
    test_thresholds();
    test_simultaneous();
    test_fwft();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
